// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control unit:
// FSM state encoding, opcode values and ALU operation selects.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // States that hold a memory request open until mem_ready
    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory-wait timeout and sticky fault.
// Outputs decode from state; FETCH/BRANCH also look at mem_ready/zero.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       pcsrc,
    output logic       regwrite,
    output logic       regdest,
    output logic       alusrc,
    output logic       memtoreg,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       fault
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t          r_state;
    logic [CW-1:0]   r_wait;
    logic [5:0]      r_opcode;
    state_t          w_next;
    logic            w_wait_st;
    logic            w_timeout;

    assign w_wait_st = is_mem_wait(r_state);
    assign w_timeout = w_wait_st && !mem_ready
                    && (r_wait == CW'(WAIT_MAX));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE:     w_next = S_EXEC_R;
                    OP_ADDI:      w_next = S_EXEC_I;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    default:      w_next = S_FAULT;
                endcase
            end
            S_EXEC_R:   w_next = S_WB_R;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = (r_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) w_next = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH:
                        w_next = S_FETCH;
            default:    w_next = S_FAULT;
        endcase
        // An acknowledge on the limit cycle wins, so only !mem_ready times out
        if (w_timeout) w_next = S_FAULT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_wait   <= '0;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_opcode <= opcode;
            if (w_wait_st && (w_next == r_state)) r_wait <= r_wait + 1'b1;
            else                                  r_wait <= '0;
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsrc    = 1'b0;
        regwrite = 1'b0;
        regdest  = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        aluop    = ALU_ADD;
        fault    = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_EXEC_R: begin
                aluop   = ALU_FUNCT;
                regdest = 1'b1;
            end
            S_WB_R: begin
                regwrite = 1'b1;
                regdest  = 1'b1;
                aluop    = ALU_FUNCT;
            end
            S_EXEC_I, S_MEM_ADDR: alusrc = 1'b1;
            S_WB_I: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
            end
            S_WB_MEM: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_BRANCH: begin
                aluop   = ALU_SUB;
                pcsrc   = 1'b1;
                pcwrite = zero;
            end
            S_FAULT:  fault = 1'b1;
            default: ;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized traffic
// checked each cycle against an instruction-plan reference model.
module tb_multicycle_ctrl;
    import mips_pkg::*;

    localparam int WM = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, irwrite, pcwrite, pcsrc;
    logic       regwrite, regdest, alusrc, memtoreg, fault;
    logic [1:0] aluop;
    logic [3:0] state;

    multicycle_ctrl #(.WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .pcsrc(pcsrc), .regwrite(regwrite), .regdest(regdest),
        .alusrc(alusrc), .memtoreg(memtoreg), .aluop(aluop),
        .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    // {mem_req,mem_we,iord,irwrite,pcwrite,pcsrc,regwrite,regdest,
    //  alusrc,memtoreg,aluop[1:0],fault}
    logic [12:0] w_out;
    assign w_out = {mem_req, mem_we, iord, irwrite, pcwrite, pcsrc,
                    regwrite, regdest, alusrc, memtoreg, aluop, fault};

    typedef struct packed {
        logic [3:0]  st;
        logic [12:0] o;
    } obs_t;

    int     vectors = 0;
    int     errors  = 0;
    obs_t   trace[$];
    state_t m_phase;
    state_t m_plan[$];
    int     m_wait;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] exp_out(state_t p, logic rdy, logic z);
        logic mr, mw, io, ir, pw, ps, rw, rd, as, mt, f;
        logic [1:0] ao;
        {mr, mw, io, ir, pw, ps, rw, rd, as, mt, f} = '0;
        ao = 2'b00;
        case (p)
            S_FETCH:    begin mr = 1; ir = rdy; pw = rdy; end
            S_EXEC_R:   begin ao = 2'b10; rd = 1; end
            S_WB_R:     begin rw = 1; rd = 1; ao = 2'b10; end
            S_EXEC_I:   as = 1;
            S_WB_I:     begin rw = 1; as = 1; end
            S_MEM_ADDR: as = 1;
            S_MEM_RD:   begin mr = 1; io = 1; end
            S_MEM_WR:   begin mr = 1; io = 1; mw = 1; end
            S_WB_MEM:   begin rw = 1; mt = 1; end
            S_BRANCH:   begin ao = 2'b01; ps = 1; pw = z; end
            S_FAULT:    f = 1;
            default:    ;
        endcase
        return {mr, mw, io, ir, pw, ps, rw, rd, as, mt, ao, f};
    endfunction

    task automatic enter(state_t p);
        m_phase = p;
        m_wait  = 1;
    endtask

    task automatic model_reset();
        m_plan.delete();
        enter(S_FETCH);
    endtask

    // Remaining phases of the instruction, chosen once the opcode is known
    task automatic build_plan(logic [5:0] op);
        m_plan.delete();
        case (op)
            6'h00: m_plan = '{S_EXEC_R, S_WB_R};
            6'h08: m_plan = '{S_EXEC_I, S_WB_I};
            6'h23: m_plan = '{S_MEM_ADDR, S_MEM_RD, S_WB_MEM};
            6'h2B: m_plan = '{S_MEM_ADDR, S_MEM_WR};
            6'h04: m_plan = '{S_BRANCH};
            default: m_plan = '{S_FAULT};
        endcase
    endtask

    task automatic model_step();
        logic waiting;
        if (m_phase == S_FAULT) return;
        waiting = (m_phase == S_FETCH) || (m_phase == S_MEM_RD)
               || (m_phase == S_MEM_WR);
        if (waiting && !mem_ready) begin
            if (m_wait > WM) enter(S_FAULT);
            else m_wait++;
            return;
        end
        if (m_phase == S_FETCH) begin
            enter(S_DECODE);
            return;
        end
        if (m_phase == S_DECODE) build_plan(opcode);
        if (m_plan.size() == 0) enter(S_FETCH);
        else enter(m_plan.pop_front());
    endtask

    task automatic cycle();
        obs_t ob;
        @(negedge clk);
        check("state", 32'(state), 32'(m_phase));
        check("outputs", 32'(w_out), 32'(exp_out(m_phase, mem_ready, zero)));
        ob.st = state;
        ob.o  = w_out;
        trace.push_back(ob);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic set_rst(logic v);
        rst = v;
        if (v) model_reset();
    endtask

    task automatic start();
        set_rst(1'b1);
        mem_ready = 1'b0;
        opcode    = 6'h00;
        zero      = 1'b0;
        cycle();
        set_rst(1'b0);
        trace.delete();
    endtask

    function automatic int count_bit(int b, int from, int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (trace[i].o[b]) n++;
        return n;
    endfunction

    function automatic int find_return();
        for (int i = 1; i < trace.size(); i++)
            if (trace[i].st == S_FETCH && trace[i-1].st != S_FETCH) return i;
        return -1;
    endfunction

    initial begin
        state_t      exp_s[5];
        logic [31:0] pat;
        logic [5:0]  op_tbl[5];
        int          stall;
        int          fcnt;
        int          n;

        rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        model_reset();
        #2;
        check("reset_state", 32'(state), 32'(S_FETCH));
        check("reset_mem_req", 32'(mem_req), 32'd1);
        check("reset_fault", 32'(fault), 32'd0);
        @(posedge clk); #1;

        // addi, zero-wait memory
        start();
        opcode = 6'h08; mem_ready = 1'b1;
        repeat (5) cycle();
        exp_s = '{S_FETCH, S_DECODE, S_EXEC_I, S_WB_I, S_FETCH};
        for (int i = 0; i < 5; i++)
            check("addi_seq", 32'(trace[i].st), 32'(exp_s[i]));
        check("addi_regwrite_pulses", count_bit(6, 0, 3), 1);
        check("addi_latency", find_return(), 4);

        // lw with two MEM_RD wait cycles; ready during DECODE is ignored
        start();
        opcode = 6'h23; pat = 32'b11100111;
        for (int i = 0; i < 8; i++) begin
            mem_ready = pat[i];
            cycle();
        end
        check("lw_latency", find_return(), 7);
        for (int i = 3; i < 6; i++)
            check("lw_wait_stable", 32'(trace[i].o[12:10]), 32'b101);
        check("lw_wb_state", 32'(trace[6].st), 32'(S_WB_MEM));
        check("lw_regwrite_pulses", count_bit(6, 0, 6), 1);
        check("lw_memtoreg_in_wb", 32'(trace[6].o[3]), 32'd1);

        // beq taken / not taken
        for (int z = 1; z >= 0; z--) begin
            start();
            opcode = 6'h04; zero = z[0]; mem_ready = 1'b1;
            repeat (4) cycle();
            check("beq_branch_state", 32'(trace[2].st), 32'(S_BRANCH));
            check("beq_pcwrite", 32'(trace[2].o[8]), 32'(z));
            check("beq_pcsrc", 32'(trace[2].o[7]), 32'd1);
            check("beq_latency", find_return(), 3);
        end

        // illegal opcode: sticky fault until reset
        start();
        opcode = 6'h3F; mem_ready = 1'b1;
        repeat (22) cycle();
        check("bad_op_fault_state", 32'(trace[2].st), 32'(S_FAULT));
        check("bad_op_fault_cycles", count_bit(0, 2, 21), 20);
        set_rst(1'b1);
        #1;
        check("bad_op_rst_state", 32'(state), 32'(S_FETCH));
        check("bad_op_rst_fault", 32'(fault), 32'd0);
        cycle();
        set_rst(1'b0);

        // sw timeout, then acknowledge on the limit cycle
        for (int k = 0; k < 2; k++) begin
            start();
            opcode = 6'h2B;
            for (int i = 0; i < 20; i++) begin
                mem_ready = (i == 0) || (k == 1 && i == 18);
                cycle();
            end
            check("sw_last_wait", 32'(trace[18].st), 32'(S_MEM_WR));
            check("sw_wait_stable", count_bit(11, 3, 18), 16);
            check("sw_after_limit", 32'(trace[19].st),
                  32'((k == 0) ? S_FAULT : S_FETCH));
        end

        // async reset in the middle of a MEM_RD wait
        start();
        opcode = 6'h23;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i < 3);
            cycle();
        end
        check("arst_pre_iord", 32'(trace[4].o[10]), 32'd1);
        #2;
        set_rst(1'b1);
        #1;
        check("arst_state", 32'(state), 32'(S_FETCH));
        check("arst_iord", 32'(iord), 32'd0);
        check("arst_mem_we", 32'(mem_we), 32'd0);
        cycle();
        set_rst(1'b0);
        trace.delete();
        opcode = 6'h08; mem_ready = 1'b1;
        repeat (2) cycle();
        check("arst_fresh_fetch", 32'(trace[0].st), 32'(S_FETCH));
        check("arst_then_decode", 32'(trace[1].st), 32'(S_DECODE));

        // randomized traffic against the model
        op_tbl = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04};
        stall = 0;
        fcnt  = 0;
        start();
        for (int c = 0; c < 4000; c++) begin
            n = $urandom_range(0, 5);
            opcode = (n == 5) ? 6'($urandom_range(0, 63)) : op_tbl[n];
            zero   = 1'($urandom_range(0, 1));
            if (stall > 0) begin
                mem_ready = 1'b0;
                stall--;
            end else begin
                mem_ready = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 99) == 0) stall = $urandom_range(10, 20);
            end
            if (m_phase == S_FAULT) fcnt++;
            if (fcnt > 3 || $urandom_range(0, 249) == 0) begin
                #2;
                set_rst(1'b1);
                cycle();
                set_rst(1'b0);
                fcnt = 0;
            end else begin
                cycle();
            end
            if (trace.size() > 64) trace.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
